pulse_replayer: RTL

// Consumer end of the pulse-timestamp stream: accepts 32-bit words {line_id[3:0], ts[27:0]}
// on an AXI-Stream slave and re-emits each event as a pulse on pulse_o[line_id] when the local
// 28-bit timebase equals ts. Sits in the ts_clk domain (loopback, playback and stimulus replay).

---
 rtl/pulse_ts_pkg.sv | 30 +++
 rtl/pulse_replayer_if.sv | 14 +
 rtl/pulse_stretcher.sv | 33 +++
 rtl/pulse_replayer.sv | 105 ++++++++++
 4 files changed

// File: rtl/pulse_ts_pkg.sv
// Shared definitions for the pulse-timestamp stream (producer and replayer).
//   TS_W/LINE_W/WORD_W : field widths of the {line_id, ts} stream word
//   ts_word_t          : unpacked view of one stream word
//   get_line/get_ts    : field slicing helpers
//   state_e            : replayer FSM states
package pulse_ts_pkg;

  localparam int unsigned TS_W   = 28;
  localparam int unsigned LINE_W = 4;
  localparam int unsigned WORD_W = 32;

  typedef struct packed {
    logic [LINE_W-1:0] line;
    logic [TS_W-1:0]   ts;
  } ts_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  function automatic logic [LINE_W-1:0] get_line(input logic [WORD_W-1:0] word);
    return word[WORD_W-1 -: LINE_W];
  endfunction

  function automatic logic [TS_W-1:0] get_ts(input logic [WORD_W-1:0] word);
    return word[TS_W-1:0];
  endfunction

endpackage

// File: rtl/pulse_replayer_if.sv
// AXI-Stream carrying {line_id, ts} words.
//   tdata  : [31:28] line_id, [27:0] target timestamp
//   tvalid : word present
//   tready : consumer accepts
interface pulse_replayer_if;
  import pulse_ts_pkg::*;

  logic [WORD_W-1:0] tdata;
  logic              tvalid;
  logic              tready;

  modport master (output tdata, output tvalid, input tready);
  modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/pulse_stretcher.sv
// Turns a one-cycle fire strobe into a PULSE_WIDTH-cycle registered level.
//   ts_clk, resetn : clock, async active-low reset
//   fire           : strobe; high in cycle c gives pulse high c+1..c+PULSE_WIDTH
//   pulse          : registered output level
// A fire while the pulse is running restarts the count, so pulses merge.
module pulse_stretcher #(
  parameter int unsigned PULSE_WIDTH = 4
) (
  input  logic ts_clk,
  input  logic resetn,
  input  logic fire,
  output logic pulse
);

  localparam int unsigned CNT_W = $clog2(PULSE_WIDTH + 1);

  logic [CNT_W-1:0] cnt;

  // cnt holds the remaining high cycles including the current one
  always_ff @(posedge ts_clk or negedge resetn) begin
    if (!resetn) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else if (fire) begin
      cnt   <= CNT_W'(PULSE_WIDTH);
      pulse <= 1'b1;
    end else begin
      if (cnt != '0) cnt <= cnt - CNT_W'(1);
      pulse <= (cnt > CNT_W'(1));
    end
  end

endmodule

// File: rtl/pulse_replayer.sv
// Replays timestamped events from the stream as pulses against a local timebase.
//   ts_clk, resetn   : clock, async active-low reset
//   enable           : runs the timebase and allows stream transfers
//   ctr_clear        : synchronous timebase clear, wins over increment
//   ts_strm          : AXI-Stream slave of {line_id, ts} words
//   pulse_o          : per-line replayed pulses
//   ts_ctr_o         : local timebase
//   late_cnt         : events fired after their timestamp (saturating)
//   drop_cnt         : stale or invalid-line events discarded (saturating)
module pulse_replayer
  import pulse_ts_pkg::*;
#(
  parameter int unsigned NUM_LINES   = 16,
  parameter int unsigned PULSE_WIDTH = 4,
  parameter int unsigned LATE_WINDOW = 64
) (
  input  logic                 ts_clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic                 ctr_clear,
  pulse_replayer_if.slave      ts_strm,
  output logic [NUM_LINES-1:0] pulse_o,
  output logic [TS_W-1:0]      ts_ctr_o,
  output logic [15:0]          late_cnt,
  output logic [15:0]          drop_cnt
);

  // Smallest unsigned difference that still reads as "late" (ds == -LATE_WINDOW)
  localparam logic [TS_W-1:0] LATE_LO = TS_W'((32'd1 << TS_W) - LATE_WINDOW);

  state_e         state;
  ts_word_t       hold;
  logic [TS_W-1:0] ctr;

  logic [TS_W-1:0]      diff_c;
  logic                 line_ok_c;
  logic                 due_c;
  logic                 late_c;
  logic                 fire_c;
  logic                 drop_c;
  logic                 xfer_c;
  logic [NUM_LINES-1:0] fire_vec_c;

  // Classify the held event against the timebase (wrap-safe modular compare)
  always_comb begin
    diff_c     = hold.ts - ctr;
    line_ok_c  = (32'(hold.line) < NUM_LINES);
    due_c      = (diff_c == '0);
    late_c     = (diff_c >= LATE_LO);
    fire_c     = 1'b0;
    drop_c     = 1'b0;
    fire_vec_c = '0;
    if (state == WAIT) begin
      if (!line_ok_c) begin
        drop_c = 1'b1;
      end else if (due_c || late_c) begin
        fire_c     = 1'b1;
        fire_vec_c = NUM_LINES'(1) << hold.line;
      end else if (diff_c[TS_W-1]) begin
        drop_c = 1'b1;
      end
    end
  end

  // The slot frees in the same cycle its event resolves, allowing back-to-back words
  assign ts_strm.tready = resetn & enable & ((state == IDLE) | fire_c | drop_c);
  assign xfer_c         = ts_strm.tvalid & ts_strm.tready;
  assign ts_ctr_o       = ctr;

  // Timebase, hold register, FSM and status counters
  always_ff @(posedge ts_clk or negedge resetn) begin
    if (!resetn) begin
      ctr      <= '0;
      state    <= IDLE;
      hold     <= '0;
      late_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (ctr_clear)   ctr <= '0;
      else if (enable) ctr <= ctr + TS_W'(1);

      if (xfer_c) begin
        hold  <= '{line: get_line(ts_strm.tdata), ts: get_ts(ts_strm.tdata)};
        state <= WAIT;
      end else if (fire_c || drop_c) begin
        state <= IDLE;
      end

      if (fire_c && !due_c && (late_cnt != 16'hFFFF)) late_cnt <= late_cnt + 16'd1;
      if (drop_c && (drop_cnt != 16'hFFFF))           drop_cnt <= drop_cnt + 16'd1;
    end
  end

  for (genvar i = 0; i < int'(NUM_LINES); i++) begin : g_line
    pulse_stretcher #(
      .PULSE_WIDTH(PULSE_WIDTH)
    ) u_stretch (
      .ts_clk (ts_clk),
      .resetn (resetn),
      .fire   (fire_vec_c[i]),
      .pulse  (pulse_o[i])
    );
  end

endmodule
